uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Transmit half of the UART, the counterpart to the Rx sampling-strobe/receiver path. It accepts one byte at a time over a valid/ready handshake and serializes it onto the `tx` line as start bit, 8 data bits LSB-first, an optional even-parity bit, and a stop bit. Bit timing comes from an internal bit-period counter that uses the same `CLOCKS_PER_BIT` convention as the receiver. It sits between the byte source (host logic or FIFO) and the TX pin.

## Interface
- `CLOCKS_PER_BIT`, default 5000 (8 under `FORMAL`): system clocks per UART bit (48 MHz / 9600 baud).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  **synchronous, active-low reset**. Sampled on the rising edge of `clk`.
- `tx_data`  in  8  byte to send. Sampled only on handshake.
- `tx_valid`  in  1  source has a byte on `tx_data`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line, idle high. Registered output.
- `tx_busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- **Handshake:** a byte is accepted on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` is copied into an 8-bit shift register.
  - The source must hold `tx_data` stable while `tx_valid` is high and `tx_ready` is low.
- **States:** IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx`=1, `tx_ready`=1. On handshake go to START and clear the bit counter.
  - START: `tx`=0 for `CLOCKS_PER_BIT` clocks, then go to DATA with bit index 0.
  - DATA: `tx` = shift-register LSB. At the end of each bit period, shift right and increment the index. After index 7 completes, go to PARITY if enabled, otherwise STOP.
  - PARITY: `tx` = XOR of the 8 captured bits (even parity), for one bit period. Then go to STOP.
  - STOP: `tx`=1 for one bit period.
- **Back-to-back frames:** `tx_ready` is also asserted in the last clock of STOP (bit counter = `CLOCKS_PER_BIT-1`).
  - A handshake in that cycle goes directly to START, so frames are contiguous with no extra idle clocks.
  - Without a handshake in that cycle, go to IDLE.
- **Bit counter:** width `$clog2(CLOCKS_PER_BIT)`.
  - Counts 0..`CLOCKS_PER_BIT-1`, then wraps to 0 and advances the state or bit index.
  - Never exceeds `CLOCKS_PER_BIT-1`.
- **Bit index:** 3 bits.
- **`tx_ready` in other states:** low in START, DATA, PARITY, and STOP except for the last STOP clock. `tx_valid` is ignored while `tx_ready` is low.
- **Reset (`rst_n`=0 at an edge), including mid-frame:**
  - State goes to IDLE; `tx`=1, `tx_busy`=0, `tx_ready`=1.
  - Counters are cleared and the partial frame is discarded. Any handshake in the same cycle is ignored.
- **Reset values:** `tx`=1, `tx_ready`=1, `tx_busy`=0.

## Timing
- **Handshake at edge k:** `tx` falls at edge k+1, and `tx_busy` rises at edge k+1.
- **Bit widths:** every bit, including start, parity and stop, lasts exactly `CLOCKS_PER_BIT` clocks on `tx`.
- **Frame length:** 10×`CLOCKS_PER_BIT` clocks, or 11× with parity enabled.
  - Data bit n occupies clocks [(1+n)·CPB, (2+n)·CPB) after the `tx` falling edge, where CPB = `CLOCKS_PER_BIT`.
- **Sustained throughput** with `tx_valid` held high: one byte per frame length, with no gap cycles.
- **`tx_ready` after a frame:** with no pending byte, `tx_ready` goes high in the last STOP clock and stays high in IDLE.

## Configuration
- **`UART_TX_PARITY_EN`**
  - Defined: the PARITY state is compiled in and an even-parity bit is inserted after data bit 7. The frame is 11 bits.
  - Undefined: the PARITY state and parity logic are absent. DATA goes directly to STOP and the frame is 10 bits.
- **Receiver pairing:** the paired receiver must be built with the same setting.

## Test plan
All scenarios use `CLOCKS_PER_BIT`=8.

1. **Reset:** hold `rst_n`=0 for 3 clocks → `tx`=1, `tx_ready`=1, `tx_busy`=0 on every cycle.
2. **Single byte, parity off:** handshake `tx_data`=8'hA5 → `tx` holds each of 0,1,0,1,0,0,1,0,1,1 for 8 clocks (80 clocks total), then `tx_busy`=0.
3. **Single byte, parity on:** with `UART_TX_PARITY_EN`, send 8'h07 → parity bit = 1 and the frame is 88 clocks. Send 8'h03 → parity bit = 0.
4. **Back-to-back:** `tx_valid` held high with 8'h55 then 8'hFF → the second start bit begins on the clock immediately after the first stop bit's 8th clock (no gap), and `tx_ready` pulses for exactly 1 clock per frame.
5. **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of 8'h00 → `tx`=1 on the next edge. A new byte sent after release produces a full, correct frame.
6. **Protocol check:** change `tx_data` while `tx_ready`=0 → no effect on the frame in flight. `tx_valid` pulsed during a busy frame is not accepted.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit half of the UART. Accepts one byte per valid/ready handshake and
// shifts it out on tx as: start bit, 8 data bits LSB first, optional even
// parity bit, stop bit. Every bit lasts CLOCKS_PER_BIT clocks.
//
// Build option: define UART_TX_PARITY_EN to compile in the even-parity bit
// (11-bit frame). Without it the frame is 10 bits and no parity logic exists.
// The paired receiver must be built with the same setting.
//
// tx and tx_busy are registered from the current state, so both trail the
// state register by one clock. A handshake at edge k therefore shows up on
// tx and tx_busy at edge k+1. tx_ready is decoded directly from the state.
// Because of that one-clock lag, a handshake during the last STOP clock
// starts the next start bit exactly when the current stop bit ends on tx.
module uart_tx_serializer #(
`ifdef FORMAL
    parameter int CLOCKS_PER_BIT = 8
`else
    parameter int CLOCKS_PER_BIT = 5000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bitDone;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bitDone = (cnt_q == CNT_LAST);
    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // Next-state, counter, shift register and line-level decode for the frame FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_ready = 1'b0;
        tx_d     = 1'b1;
        busy_d   = (state_q != S_IDLE);
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                tx_d     = 1'b1;
                cnt_d    = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = S_START;
                end
            end

            S_START: begin
                tx_d = 1'b0;
                if (bitDone) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                tx_d = shift_q[0];
                if (bitDone) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = par_q;
                if (bitDone) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                tx_d = 1'b1;
                if (bitDone) begin
                    tx_ready = 1'b1;
                    cnt_d    = '0;
                    if (tx_valid) begin
                        shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^tx_data;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
